// File: rtl/oled_i2c_wr_if.sv
// Request/response and pad signals between the display sequencer, the I2C write
// engine and the SCL/SDA pads.
interface oled_i2c_wr_if;
   logic       i2c_wen;
   logic [7:0] reg_addr;
   logic [7:0] reg_data;
   logic       busy;
   logic       i2c_done;
   logic       ack_err;
   logic       scl;
   logic       sda_oe;
   logic       sda_in;

   // Sequencer plus pad side.
   modport master (
      output i2c_wen, reg_addr, reg_data, sda_in,
      input  busy, i2c_done, ack_err, scl, sda_oe
   );

   // Write engine side.
   modport slave (
      input  i2c_wen, reg_addr, reg_data, sda_in,
      output busy, i2c_done, ack_err, scl, sda_oe
   );
endinterface

// File: rtl/oled_i2c_wr.sv
// Write-only I2C master: START, {DEV_ADDR,0}, reg_addr, reg_data, STOP.
// Each bus segment is four quarters of CLK_DIV clocks; every pad output is registered.
module oled_i2c_wr #(
   parameter int         CLK_DIV  = 125,
   parameter logic [6:0] DEV_ADDR = 7'h3C
) (
   input  logic          clk,
   input  logic          rst,
   oled_i2c_wr_if.slave  bus
);
   localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [1:0]    qtr_q, qtr_d;
   logic [2:0]    bit_q, bit_d;
   logic [1:0]    byte_q, byte_d;
   logic [7:0]    addr_q, addr_d, data_q, data_d;
   logic          nack_q, nack_d, err_q, err_d;
   logic          done_q, done_d, busy_q, busy_d;
   logic          scl_q, scl_d, oe_q, oe_d;
   logic          tick_last, seg_end;
   logic [7:0]    cur_byte;

   always_comb begin
      state_d   = state_q;
      tick_d    = '0;
      qtr_d     = '0;
      bit_d     = bit_q;
      byte_d    = byte_q;
      addr_d    = addr_q;
      data_d    = data_q;
      nack_d    = nack_q;
      err_d     = err_q;
      tick_last = (tick_q == TW'(CLK_DIV - 1));
      seg_end   = tick_last && (qtr_q == 2'd3);

      if (state_q != S_IDLE && state_q != S_DONE) begin
         tick_d = tick_last ? '0 : tick_q + TW'(1);
         qtr_d  = tick_last ? qtr_q + 2'd1 : qtr_q;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (bus.i2c_wen) begin
               state_d = S_START;
               addr_d  = bus.reg_addr;
               data_d  = bus.reg_data;
               byte_d  = 2'd0;
               bit_d   = 3'd7;
               err_d   = 1'b0;
            end
         end
         S_START: if (seg_end) begin
            state_d = S_BIT;
            bit_d   = 3'd7;
         end
         S_BIT: if (seg_end) begin
            if (bit_q == 3'd0) state_d = S_ACK;
            else               bit_d   = bit_q - 3'd1;
         end
         S_ACK: begin
            // Slave response is taken on the last clock of the SCL-high window.
            if (qtr_q == 2'd2 && tick_last) nack_d = bus.sda_in;
            if (seg_end) begin
               if (nack_q) begin
                  err_d   = 1'b1;
                  state_d = S_STOP;
               end else if (byte_q == 2'd2) begin
                  state_d = S_STOP;
               end else begin
                  byte_d  = byte_q + 2'd1;
                  bit_d   = 3'd7;
                  state_d = S_BIT;
               end
            end
         end
         S_STOP: if (seg_end) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   // Pad levels are derived from the next state so the registered pins line up with it.
   always_comb begin
      cur_byte = data_d;
      case (byte_d)
         2'd0:    cur_byte = {DEV_ADDR, 1'b0};
         2'd1:    cur_byte = addr_d;
         default: cur_byte = data_d;
      endcase

      scl_d = 1'b1;
      oe_d  = 1'b0;
      case (state_d)
         S_START: begin
            scl_d = (qtr_d != 2'd3);
            oe_d  = qtr_d[1];
         end
         S_BIT: begin
            scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
            oe_d  = ~cur_byte[bit_d];
         end
         S_ACK: scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
         S_STOP: begin
            scl_d = (qtr_d != 2'd0);
            oe_d  = ~qtr_d[1];
         end
         default: ;
      endcase

      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         tick_q  <= '0;
         qtr_q   <= '0;
         bit_q   <= 3'd7;
         byte_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         nack_q  <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         scl_q   <= 1'b1;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         qtr_q   <= qtr_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         nack_q  <= nack_d;
         err_q   <= err_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         scl_q   <= scl_d;
         oe_q    <= oe_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.i2c_done = done_q;
   assign bus.ack_err  = err_q;
   assign bus.scl      = scl_q;
   assign bus.sda_oe   = oe_q;
endmodule

// File: tb/tb_oled_i2c_wr.sv
// Bench for oled_i2c_wr: segment-level waveform model compared every cycle, a bus-decoding
// slave that ACKs/NACKs per byte, and directed plus random transfers.
module tb_oled_i2c_wr;
   localparam int         CLK_DIV = 4;
   localparam int         SEG     = 4 * CLK_DIV;
   localparam logic [6:0] DEV     = 7'h3C;

   logic clk = 1'b0;
   logic rst = 1'b1;
   oled_i2c_wr_if bus();

   oled_i2c_wr #(.CLK_DIV(CLK_DIV), .DEV_ADDR(DEV)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_en  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transaction-level model: one active write described by its start cycle and segment count.
   int         nack_byte = 3;
   bit         m_act = 0, m_nack = 0, m_err_hold = 0;
   int         m_t0 = 0, m_S = 0, m_nb = 0, acc_cnt = 0, acc_cyc = 0;
   logic [7:0] m_b [3];

   always @(posedge clk) begin : model
      bit free;
      if (rst) begin
         m_act      = 0;
         m_err_hold = 0;
      end else begin
         free = !m_act || (cyc == m_t0 + m_S * SEG);
         if (m_act && cyc == m_t0 + m_S * SEG) begin
            m_act      = 0;
            m_err_hold = m_nack;
         end
         if (free && bus.i2c_wen === 1'b1) begin
            m_act      = 1;
            m_t0       = cyc + 1;
            m_b        = '{{DEV, 1'b0}, bus.reg_addr, bus.reg_data};
            m_nack     = (nack_byte < 3);
            m_nb       = m_nack ? nack_byte + 1 : 3;
            m_S        = 2 + 9 * m_nb;
            m_err_hold = 0;
            acc_cnt++;
            acc_cyc    = cyc;
         end
      end
      cyc++;
   end

   task automatic exp_out(input int c, output logic e_scl, output logic e_oe,
                          output logic e_busy, output logic e_done, output logic e_err);
      int k, seg, q, idx, bi, pos;
      e_scl = 1'b1; e_oe = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_err = m_err_hold;
      if (m_act) begin
         k     = c - m_t0;
         e_err = 1'b0;
         if (k == m_S * SEG) begin
            e_done = 1'b1;
            e_err  = m_nack;
         end else begin
            seg    = k / SEG;
            q      = (k % SEG) / CLK_DIV;
            e_busy = 1'b1;
            if (m_nack && seg == m_S - 1) e_err = 1'b1;
            if (seg == 0) begin
               e_scl = (q != 3);
               e_oe  = (q >= 2);
            end else if (seg == m_S - 1) begin
               e_scl = (q != 0);
               e_oe  = (q < 2);
            end else begin
               idx   = seg - 1;
               bi    = idx / 9;
               pos   = idx % 9;
               e_scl = (q == 1 || q == 2);
               e_oe  = (pos < 8) ? ~m_b[bi][7 - pos] : 1'b0;
            end
         end
      end
   endtask

   int done_cnt = 0, last_done = 0;
   bit err_at_done = 0;

   always @(negedge clk) begin : compare
      logic e_scl, e_oe, e_busy, e_done, e_err;
      if (chk_en) begin
         exp_out(cyc, e_scl, e_oe, e_busy, e_done, e_err);
         chk("scl",      bus.scl,      e_scl);
         chk("sda_oe",   bus.sda_oe,   e_oe);
         chk("busy",     bus.busy,     e_busy);
         chk("i2c_done", bus.i2c_done, e_done);
         chk("ack_err",  bus.ack_err,  e_err);
      end
      if (bus.i2c_done === 1'b1) begin
         done_cnt++;
         last_done   = cyc;
         err_at_done = bus.ack_err;
      end
   end

   // Bus slave: decodes bytes from SCL/SDA and drives the ACK bit.
   logic [7:0] rx [$];
   bit         started = 0, skip = 0, pull = 0;
   int         bitcnt = 0, bytecnt = 0, start_cnt = 0, stop_cnt = 0;
   logic [7:0] sh = '0;
   logic       p_scl = 1'b1, p_oe = 1'b0;

   assign bus.sda_in = ~(bus.sda_oe | pull);

   always @(negedge clk) begin : slave
      if (bus.scl === 1'b1 && p_scl === 1'b1 && p_oe === 1'b0 && bus.sda_oe === 1'b1) begin
         started = 1; skip = 1; pull = 0; bitcnt = 0; bytecnt = 0;
         start_cnt++;
      end else if (bus.scl === 1'b1 && p_scl === 1'b1 && p_oe === 1'b1 && bus.sda_oe === 1'b0) begin
         started = 0; pull = 0;
         stop_cnt++;
      end else if (started && p_scl === 1'b1 && bus.scl === 1'b0) begin
         if (skip) skip = 0;
         else begin
            bitcnt++;
            if (bitcnt == 8) pull = (bytecnt != nack_byte);
            else if (bitcnt == 9) begin
               pull = 0; bitcnt = 0; bytecnt++;
            end
         end
      end else if (started && p_scl === 1'b0 && bus.scl === 1'b1) begin
         if (bitcnt < 8) begin
            sh = {sh[6:0], ~bus.sda_oe};
            if (bitcnt == 7) rx.push_back(sh);
         end
      end
      p_scl = bus.scl;
      p_oe  = bus.sda_oe;
   end

   function automatic int rx_at(input int i);
      if (i < rx.size()) return int'(rx[i]);
      return -1;
   endfunction

   task automatic start_xfer(input logic [7:0] a, input logic [7:0] d, input int nb);
      @(negedge clk);
      nack_byte    = nb;
      bus.reg_addr = a;
      bus.reg_data = d;
      bus.i2c_wen  = 1'b1;
      @(negedge clk);
      bus.i2c_wen  = 1'b0;
      bus.reg_addr = 8'($urandom);
      bus.reg_data = 8'($urandom);
   endtask

   task automatic wait_done(output int dc);
      int d0 = done_cnt;
      int n  = 0;
      while (done_cnt == d0 && n < 3000) begin
         @(posedge clk);
         n++;
      end
      chk("done_seen", done_cnt != d0, 1);
      dc = last_done;
      @(negedge clk);
   endtask

   task automatic full_write(input logic [7:0] a, input logic [7:0] d, input int nb, input string tag);
      int ac, dc, nbytes, d0;
      logic [7:0] exp_b [3];
      exp_b  = '{8'h78, a, d};
      nbytes = (nb < 3) ? nb + 1 : 3;
      d0     = stop_cnt;
      rx.delete();
      start_xfer(a, d, nb);
      ac = acc_cyc;
      wait_done(dc);
      chk({tag, "_latency"}, dc - ac, 1 + (2 + 9 * nbytes) * SEG);
      chk({tag, "_ack_err"}, err_at_done, (nb < 3));
      chk({tag, "_nbytes"}, rx.size(), nbytes);
      for (int i = 0; i < nbytes; i++) chk({tag, "_byte"}, rx_at(i), int'(exp_b[i]));
      chk({tag, "_stops"}, stop_cnt - d0, 1);
   endtask

   initial begin
      int ac, dc, d1, d2, a1, d0, tgt, n;
      logic [7:0] rd;
      bus.i2c_wen  = 1'b0;
      bus.reg_addr = '0;
      bus.reg_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_en = 1;
      chk("rst_scl", bus.scl, 1);
      chk("rst_sda_oe", bus.sda_oe, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.i2c_done, 0);
      chk("rst_ack_err", bus.ack_err, 0);

      // Full write, then NACK on address, then NACK on register byte.
      full_write(8'h00, 8'hAF, 3, "s1");
      @(negedge clk);
      chk("s1_idle_scl", bus.scl, 1);
      chk("s1_idle_oe", bus.sda_oe, 0);
      full_write(8'h12, 8'h34, 0, "s2");
      full_write(8'h56, 8'h78, 1, "s3");

      // Requests while busy are dropped.
      rd = 8'($urandom);
      d0 = done_cnt;
      rx.delete();
      start_xfer(8'h9C, rd, 3);
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(20, 90)) @(negedge clk);
         bus.reg_data = 8'h55;
         bus.i2c_wen  = 1'b1;
         @(negedge clk);
         bus.i2c_wen  = 1'b0;
      end
      wait_done(dc);
      repeat (30) @(negedge clk);
      chk("s4_done_pulses", done_cnt - d0, 1);
      chk("s4_data_byte", rx_at(2), int'(rd));
      chk("s4_addr_byte", rx_at(1), 32'h9C);

      // Held request: second accept lands in the DONE cycle.
      rx.delete();
      nack_byte = 3;
      @(negedge clk);
      bus.reg_addr = 8'h3A;
      bus.reg_data = 8'hA1;
      bus.i2c_wen  = 1'b1;
      @(negedge clk);
      a1 = acc_cyc;
      bus.reg_data = 8'hA2;
      wait_done(d1);
      bus.i2c_wen = 1'b0;
      chk("s5_first_latency", d1 - a1, 465);
      chk("s5_accept_in_done", acc_cyc, d1);
      wait_done(d2);
      chk("s5_spacing", d2 - d1, 465);
      chk("s5_byte_a1", rx_at(2), 32'hA1);
      chk("s5_byte_a2", rx_at(5), 32'hA2);

      // One-cycle reset inside the reg_data byte.
      start_xfer(8'h12, 8'h34, 3);
      ac  = acc_cyc;
      d0  = done_cnt;
      tgt = ac + 1 + 19 * SEG + int'($urandom_range(0, 8 * SEG - 1));
      n   = 0;
      while (cyc < tgt && n < 1000) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("s6_scl", bus.scl, 1);
      chk("s6_sda_oe", bus.sda_oe, 0);
      chk("s6_busy", bus.busy, 0);
      repeat (40) @(negedge clk);
      chk("s6_no_done", done_cnt - d0, 0);
      full_write(8'h00, 8'hAF, 3, "s6b");

      // Random transfers with random ACK policy.
      for (int t = 0; t < 6; t++)
         full_write(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), "rnd");

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end
endmodule
